// File: rtl/digest_hex_streamer_pkg.sv
// Shared constants and types for the digest hex streamer.
// ASCII codes, state encoding and digest width.
package digest_hex_streamer_pkg;

  localparam int DIGEST_W = 128;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_A_LO = 8'h61;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1
  } state_e;

endpackage

// File: rtl/digest_hex_streamer_nibble_to_ascii.sv
// Maps one 4-bit nibble to its ASCII hex character.
// Letter case is fixed at elaboration time.
module nibble_to_ascii
  import digest_hex_streamer_pkg::*;
#(
  parameter bit UPPERCASE = 1'b0
) (
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);

  logic [7:0] alpha_base;

  assign alpha_base = UPPERCASE ? ASCII_A_UP : ASCII_A_LO;

  // digits map from '0', letters from 'a' or 'A'
  always_comb begin
    ascii_o = ASCII_0;
    unique case (1'b1)
      (nib_i < 4'd10): ascii_o = ASCII_0 + {4'h0, nib_i};
      default:         ascii_o = alpha_base + {4'h0, nib_i} - 8'd10;
    endcase
  end

endmodule

// File: rtl/digest_hex_streamer.sv
// Streams a captured 128-bit digest as ASCII hex to a usart.
// One character per usart frame, optional CR LF trailer.
module digest_hex_streamer
  import digest_hex_streamer_pkg::*;
#(
  parameter int UPPERCASE   = 0,
  parameter int APPEND_CRLF = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DIGEST_W-1:0] digest,
  input  logic                digest_valid,
  output logic                busy,
  output logic                done,
  output logic [7:0]          bytetosend,
  output logic                send,
  input  logic                sent
);

  localparam int NUM_CHARS =
    32 + 2 * ((APPEND_CRLF != 0) ? 1 : 0);
  localparam logic [5:0] LAST_IDX = 6'(NUM_CHARS - 1);

  state_e              state_q;
  logic [DIGEST_W-1:0] digest_q;
  logic [5:0]          idx_q;
  logic [7:0]          byte_q;
  logic                send_q;
  logic                busy_q;
  logic                done_q;
  logic                sent_q;

  logic [5:0]          idx_d;
  logic [DIGEST_W-1:0] src;
  logic [3:0]          nib;
  logic [7:0]          hex_ch;
  logic [7:0]          char_d;
  logic                sent_evt;
  logic                accept;

  // index of the character to load next: 0 on start, else idx+1
  assign idx_d = (state_q == ST_IDLE) ? 6'd0 : idx_q + 6'd1;

  // first character comes straight from the incoming digest
  assign src = (state_q == ST_IDLE) ? digest : digest_q;
  assign nib = src[(DIGEST_W - 1) - 4 * int'(idx_d[4:0]) -: 4];

  assign sent_evt = sent & ~sent_q;
  assign accept   = digest_valid & ~done_q;

  nibble_to_ascii #(
    .UPPERCASE (UPPERCASE != 0)
  ) u_nib (
    .nib_i   (nib),
    .ascii_o (hex_ch)
  );

  // hex text first, then the CR LF trailer positions
  always_comb begin
    char_d = hex_ch;
    unique case (1'b1)
      (idx_d == 6'd32): char_d = ASCII_CR;
      (idx_d == 6'd33): char_d = ASCII_LF;
      default:          char_d = hex_ch;
    endcase
  end

  // completion strobe is the rising edge of sent
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sent_q <= 1'b0;
    else        sent_q <= sent;
  end

  // capture/stream controller; send drops on the final edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      digest_q <= '0;
      idx_q    <= 6'd0;
      byte_q   <= 8'h00;
      send_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            digest_q <= digest;
            idx_q    <= 6'd0;
            byte_q   <= char_d;
            send_q   <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (sent_evt) begin
            if (idx_q == LAST_IDX) begin
              send_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              idx_q  <= idx_d;
              byte_q <= char_d;
            end
          end
        end
        default: begin
          send_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bytetosend = byte_q;
  assign send       = send_q;

endmodule
